fifo_fill_sequencer: RTL and testbench

FIFO_FILL_SEQUENCER -- requirements
Module: fifo_fill_sequencer

---
 rtl/fifo_fill_pkg.sv | 11 +
 rtl/fill_row_counter.sv | 55 +++++
 rtl/fifo_fill_sequencer.sv | 106 ++++++++++
 tb/tb_fifo_fill_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_fill_pkg.sv
// Shared constants for the FIFO fill sequencer: default geometry and FSM state encoding.
package fifo_fill_pkg;

  localparam int unsigned DEF_WIDTH_HEIGHT = 16;
  localparam int unsigned DEF_ADDR_WIDTH   = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fill_row_counter.sv
// Row counter for a fill: latches base/row count (clamped to the array height)
// and produces the current wrapped read address plus a last-row flag.
module fill_row_counter
  import fifo_fill_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned ROW_W        = $clog2(WIDTH_HEIGHT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ROW_W-1:0]      rows_in,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ROW_W-1:0] MAX_ROWS = ROW_W'(WIDTH_HEIGHT);

  logic [ROW_W-1:0]      row_q, row_d;
  logic [ROW_W-1:0]      rows_q, rows_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  always_comb begin
    row_d  = row_q;
    rows_d = rows_q;
    base_d = base_q;
    if (load) begin
      row_d  = '0;
      base_d = base_in;
      rows_d = (rows_in > MAX_ROWS) ? MAX_ROWS : rows_in;
    end else if (advance) begin
      row_d = row_q + ROW_W'(1);
    end
  end

  // Address wraps naturally modulo 2^ADDR_WIDTH.
  assign addr = base_q + ADDR_WIDTH'(row_q);
  assign last = (row_q == (rows_q - ROW_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      rows_q <= '0;
      base_q <= '0;
    end else begin
      row_q  <= row_d;
      rows_q <= rows_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/fifo_fill_sequencer.sv
// Sequences per-column weight-memory reads into FIFO lanes, one row per unstalled cycle,
// with FIFO writes aligned one cycle behind the reads.
module fifo_fill_sequencer
  import fifo_fill_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned ROW_W        = $clog2(WIDTH_HEIGHT) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ROW_W-1:0]                   num_rows,
  input  logic [WIDTH_HEIGHT-1:0]            col_mask,
  input  logic                               stall,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] weightMem_rd_addr,
  output logic [WIDTH_HEIGHT-1:0]            weightMem_rd_en,
  output logic [WIDTH_HEIGHT-1:0]            fifo_wr_en,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  logic [1:0]              state_q, state_d;
  logic [WIDTH_HEIGHT-1:0] mask_q, mask_d;
  logic [WIDTH_HEIGHT-1:0] fifo_wr_en_q, fifo_wr_en_d;
  logic                    err_q, err_d;
  logic [WIDTH_HEIGHT-1:0] rd_en;
  logic                    load;
  logic                    advance;
  logic                    last;
  logic [ADDR_WIDTH-1:0]   addr;

  fill_row_counter #(
    .WIDTH_HEIGHT(WIDTH_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .ROW_W       (ROW_W)
  ) u_row_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .base_in(base_addr),
    .rows_in(num_rows),
    .last   (last),
    .addr   (addr)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    err_d        = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;
    rd_en        = ((state_q == ST_READ) && !stall) ? mask_q : '0;
    fifo_wr_en_d = abort ? '0 : rd_en;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            state_d = ST_READ;
            load    = 1'b1;
            mask_d  = col_mask;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          advance = 1'b1;
          if (last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign weightMem_rd_addr = {WIDTH_HEIGHT{addr}};
  assign weightMem_rd_en   = rd_en;
  assign fifo_wr_en        = fifo_wr_en_q;
  assign busy              = (state_q != ST_IDLE);
  // An abort landing on the drain cycle cancels the completion pulse.
  assign done              = (state_q == ST_DRAIN) && !abort;
  assign err               = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      fifo_wr_en_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_fill_sequencer.sv
// Self-checking bench for fifo_fill_sequencer: directed table, stall/abort/reset sequences,
// and randomized fills checked against a row-by-row transaction model.
module tb_fifo_fill_sequencer;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [7:0]     base_addr;
  logic [4:0]     num_rows;
  logic [15:0]    col_mask;
  logic           stall;
  logic [127:0]   rd_addr;
  logic [15:0]    rd_en;
  logic [15:0]    fifo_wr_en;
  logic           busy;
  logic           done;
  logic           err;

  int total = 0;
  int bad   = 0;

  fifo_fill_sequencer #(
    .WIDTH_HEIGHT(16),
    .ADDR_WIDTH  (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .base_addr        (base_addr),
    .num_rows         (num_rows),
    .col_mask         (col_mask),
    .stall            (stall),
    .weightMem_rd_addr(rd_addr),
    .weightMem_rd_en  (rd_en),
    .fifo_wr_en       (fifo_wr_en),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    int          rows;
    logic [15:0] mask;
    int          exp_reads;
    bit          exp_err;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [7:0] a);
    return {16{a}};
  endfunction

  function automatic int clampr(input int r);
    return (r > 16) ? 16 : r;
  endfunction

  // One fill transaction. Expected behaviour: each unstalled busy cycle issues the
  // next row (addr = base + rows issued so far), stalled cycles issue nothing, FIFO
  // writes mirror the previous cycle's reads, and done arrives on the cycle after the last row.
  task automatic run_txn(input logic [7:0] b, input int rows, input logic [15:0] m,
                         input int stall_pct, input int st_at, input int st_len,
                         input bit swb, output int reads, output bit saw_err);
    int k, cyc, nst, st_cnt, nr;
    bit finished;
    logic [15:0] exp_prev;
    logic [7:0]  a;
    k = 0; cyc = 0; nst = 0; st_cnt = 0; finished = 0;
    exp_prev = '0; reads = 0; saw_err = 0;
    nr = clampr(rows);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_rows = rows[4:0]; col_mask = m; stall = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (rows == 0) begin
      #1;
      saw_err = err;
      chk("reject_busy", 128'(busy), 128'(0));
      @(posedge clk); #2;
      chk("err_single_pulse", 128'(err), 128'(0));
      chk("reject_idle", 128'(busy), 128'(0));
      return;
    end
    while (cyc < 200) begin
      cyc++;
      stall = 1'b0;
      if (k == st_at && st_cnt < st_len) begin
        stall = 1'b1;
        st_cnt++;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        stall = 1'b1;
      end
      if (swb && k < nr) begin
        start = 1'b1; base_addr = b ^ 8'h55; num_rows = 5'd3; col_mask = ~m;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("busy", 128'(busy), 128'(1));
      chk("fifo_wr_en", 128'(fifo_wr_en), 128'(exp_prev));
      if (err) saw_err = 1;
      if (done) begin
        chk("reads_before_done", 128'(k), 128'(nr));
        chk("done_latency", 128'(cyc), 128'(nr + nst + 1));
        chk("drain_rd_en", 128'(rd_en), 128'(0));
        finished = 1;
        break;
      end
      a = b + k[7:0];
      chk("rd_addr", rd_addr, rep(a));
      if (stall) begin
        chk("stall_rd_en", 128'(rd_en), 128'(0));
        exp_prev = '0;
        nst++;
      end else begin
        chk("rd_en", 128'(rd_en), 128'(m));
        exp_prev = m;
        k++;
      end
      if (k > nr) begin
        chk("overrun", 128'(k), 128'(nr));
        break;
      end
      @(posedge clk); #1;
    end
    if (!finished) chk("done_timeout", 128'(finished), 128'(1));
    start = 1'b0; stall = 1'b0;
    @(posedge clk); #2;
    chk("idle_after_done", 128'(busy), 128'(0));
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("wr_en_after_drain", 128'(fifo_wr_en), 128'(0));
    reads = k;
  endtask

  initial begin
    int reads;
    bit se;
    int rows;
    logic [7:0]  rb;
    logic [15:0] rm;
    bit swb;

    vt[0] = '{8'h20, 16, 16'hFFFF, 16, 1'b0};
    vt[1] = '{8'hFE,  4, 16'h00F0,  4, 1'b0};
    vt[2] = '{8'h00,  0, 16'hFFFF,  0, 1'b1};
    vt[3] = '{8'h10, 20, 16'hFFFF, 16, 1'b0};
    vt[4] = '{8'h30,  1, 16'h0001,  1, 1'b0};
    vt[5] = '{8'h40,  5, 16'h0000,  5, 1'b0};
    vt[6] = '{8'h7F, 31, 16'hA5A5, 16, 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    base_addr = '0; num_rows = '0; col_mask = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rd_en", 128'(rd_en), 128'(0));
    chk("reset_rd_addr", rd_addr, 128'(0));
    chk("reset_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("reset_busy_done_err", 128'({busy, done, err}), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].base, vt[i].rows, vt[i].mask, 0, -1, 0, 1'b0, reads, se);
      chk($sformatf("vec%0d_reads", i), 128'(reads), 128'(vt[i].exp_reads));
      chk($sformatf("vec%0d_err", i), 128'(se), 128'(vt[i].exp_err));
    end

    // Stall for 3 cycles once rows 0..4 have issued: addr holds 0x25, done at cycle 20.
    run_txn(8'h20, 16, 16'hFFFF, 0, 5, 3, 1'b0, reads, se);
    chk("stall_reads", 128'(reads), 128'(16));

    // Start held high while busy must not disturb the fill nor raise err.
    run_txn(8'h60, 6, 16'h0FF0, 0, -1, 0, 1'b1, reads, se);
    chk("swb_reads", 128'(reads), 128'(6));
    chk("swb_err", 128'(se), 128'(0));

    // Abort at row 7.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h20; num_rows = 5'd16; col_mask = 16'hFFFF; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    #1;
    chk("abort_row7_addr", rd_addr, rep(8'h27));
    chk("abort_row7_rd_en", 128'(rd_en), 128'(16'hFFFF));
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    chk("abort_idle", 128'(busy), 128'(0));
    chk("abort_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("abort_no_done", 128'(done), 128'(0));
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #2;
      chk("abort_quiet", 128'({busy, done}), 128'(0));
    end
    run_txn(8'h20, 16, 16'hFFFF, 0, -1, 0, 1'b0, reads, se);
    chk("after_abort_reads", 128'(reads), 128'(16));

    // Asynchronous reset between edges mid-READ.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h90; num_rows = 5'd10; col_mask = 16'h3C3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rd_en", 128'(rd_en), 128'(0));
    chk("async_rd_addr", rd_addr, 128'(0));
    chk("async_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("async_busy_done_err", 128'({busy, done, err}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 15; r++) begin
      @(posedge clk); #2;
      chk("post_reset_quiet", 128'({busy, done}), 128'(0));
    end

    for (int t = 0; t < 25; t++) begin
      rows = int'($urandom_range(20, 0));
      rb   = 8'($urandom);
      rm   = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
      swb  = 1'($urandom_range(1));
      run_txn(rb, rows, rm, 25, -1, 0, swb, reads, se);
      chk("rand_reads", 128'(reads), 128'((rows == 0) ? 0 : clampr(rows)));
      chk("rand_err", 128'(se), 128'(rows == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
